// File: rtl/fpu_pkg.sv
// Shared definitions for the FP multiplier normalize/round/pack stage.
// Holds the state encoding, exception codes and exponent constants.
package fpu_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StNorm,
    StRound,
    StPack,
    StHold
  } FpRoundState;

  localparam logic [1:0] EXC_NONE = 2'b00;
  localparam logic [1:0] EXC_OVF  = 2'b01;
  localparam logic [1:0] EXC_UNF  = 2'b10;

  localparam int unsigned       EXP_BIAS = 127;
  localparam logic signed [9:0] EXP_MAX  = 10'sd255;

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a normalized 23-bit fraction.
// Ports:
//   mant_i  fraction before rounding
//   g_i     guard bit (first dropped bit)
//   s_i     sticky bit (OR of all lower dropped bits)
//   exp_i   signed 10-bit exponent
//   mant_o  rounded fraction
//   exp_o   exponent, bumped when the fraction rolls over
module fp_rne_round (
  input  logic [22:0]       mant_i,
  input  logic              g_i,
  input  logic              s_i,
  input  logic signed [9:0] exp_i,
  output logic [22:0]       mant_o,
  output logic signed [9:0] exp_o
);

  logic        round_up;
  logic [23:0] sum;

  // Ties (G=1, S=0) round up only when the LSB is odd.
  assign round_up = g_i & (s_i | mant_i[0]);
  assign sum      = {1'b0, mant_i} + {23'd0, round_up};

  // On carry-out the low 23 bits are already zero: 1.111.. + ulp = 10.000..
  assign mant_o = sum[22:0];
  assign exp_o  = sum[23] ? (exp_i + 10'sd1) : exp_i;

endmodule

// File: rtl/fpmul_round.sv
// Normalize/round/pack stage of the single-precision FP multiplier.
// Captures the 48-bit mantissa product on the multiplier's done pulse, then
// normalizes, rounds (RNE), checks overflow/underflow and presents a packed
// IEEE-754 single under a valid/ack handshake. Denormals flush to signed zero.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   prod_i          48-bit product of two 1.23 mantissas
//   prod_valid_i    one-cycle capture strobe (ignored outside idle)
//   sign_i          result sign
//   exp_i           signed e1+e2-127 before normalization
//   zero_i          an operand was zero
//   result_o        packed {sign, exp[7:0], frac[22:0]}
//   exc_o           00 none, 01 overflow, 10 underflow
//   out_valid_o     result available until accepted
//   out_ack_i       consumer accept
//   busy_o          high whenever not idle
module fpmul_round
  import fpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [47:0]       prod_i,
  input  logic              prod_valid_i,
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic              zero_i,
  output logic [31:0]       result_o,
  output logic [1:0]        exc_o,
  output logic              out_valid_o,
  input  logic              out_ack_i,
  output logic              busy_o
);

  FpRoundState state_q, state_d;

  logic [47:0]       prod_q, prod_d;
  logic              sign_q, sign_d;
  logic              zero_q, zero_d;
  logic signed [9:0] exp_q, exp_d;
  logic [22:0]       mant_q, mant_d;
  logic              g_q, g_d;
  logic              s_q, s_d;
  logic [31:0]       result_q, result_d;
  logic [1:0]        exc_q, exc_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic [22:0]       rnd_mant;
  logic signed [9:0] rnd_exp;

  fp_rne_round u_round (
    .mant_i (mant_q),
    .g_i    (g_q),
    .s_i    (s_q),
    .exp_i  (exp_q),
    .mant_o (rnd_mant),
    .exp_o  (rnd_exp)
  );

  always_comb begin
    state_d  = state_q;
    prod_d   = prod_q;
    sign_d   = sign_q;
    zero_d   = zero_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    g_d      = g_q;
    s_d      = s_q;
    result_d = result_q;
    exc_d    = exc_q;

    unique case (state_q)
      StIdle: begin
        if (prod_valid_i) begin
          prod_d  = prod_i;
          sign_d  = sign_i;
          zero_d  = zero_i;
          exp_d   = exp_i;
          state_d = StNorm;
        end
      end
      StNorm: begin
        // Product of two [1,2) mantissas lies in [1,4): leading one is bit 47 or 46.
        if (prod_q[47]) begin
          mant_d = prod_q[46:24];
          g_d    = prod_q[23];
          s_d    = |prod_q[22:0];
          exp_d  = exp_q + 10'sd1;
        end else begin
          mant_d = prod_q[45:23];
          g_d    = prod_q[22];
          s_d    = |prod_q[21:0];
        end
        state_d = StRound;
      end
      StRound: begin
        mant_d  = rnd_mant;
        exp_d   = rnd_exp;
        state_d = StPack;
      end
      StPack: begin
        if (zero_q || (prod_q == 48'd0)) begin
          result_d = {sign_q, 31'd0};
          exc_d    = EXC_NONE;
        end else if (exp_q >= EXP_MAX) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          exc_d    = EXC_OVF;
        end else if (exp_q <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          exc_d    = EXC_UNF;
        end else begin
          result_d = {sign_q, exp_q[7:0], mant_q};
          exc_d    = EXC_NONE;
        end
        state_d = StHold;
      end
      StHold: begin
        if (out_ack_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered decodes of the next state keep the outputs glitch-free.
    out_valid_d = (state_d == StHold);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      prod_q      <= '0;
      sign_q      <= 1'b0;
      zero_q      <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      g_q         <= 1'b0;
      s_q         <= 1'b0;
      result_q    <= '0;
      exc_q       <= EXC_NONE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      prod_q      <= prod_d;
      sign_q      <= sign_d;
      zero_q      <= zero_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      g_q         <= g_d;
      s_q         <= s_d;
      result_q    <= result_d;
      exc_q       <= exc_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign result_o    = result_q;
  assign exc_o       = exc_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_fpmul_round.sv
// Self-checking bench for fpmul_round: directed vectors, an arithmetic
// reference model, and a per-cycle output compare against a scoreboard.
module tb_fpmul_round;

  logic              clk_i;
  logic              rst_ni;
  logic [47:0]       prod_i;
  logic              prod_valid_i;
  logic              sign_i;
  logic signed [9:0] exp_i;
  logic              zero_i;
  logic [31:0]       result_o;
  logic [1:0]        exc_o;
  logic              out_valid_o;
  logic              out_ack_i;
  logic              busy_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_res_q[$];
  logic [1:0]  exp_exc_q[$];

  fpmul_round dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .prod_i       (prod_i),
    .prod_valid_i (prod_valid_i),
    .sign_i       (sign_i),
    .exp_i        (exp_i),
    .zero_i       (zero_i),
    .result_o     (result_o),
    .exc_o        (exc_o),
    .out_valid_o  (out_valid_o),
    .out_ack_i    (out_ack_i),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: the product value is p * 2^-46; keep 24 significant bits,
  // round the discarded remainder to nearest, ties to even.
  function automatic void model(input logic [47:0] p, input int e_in, input bit s, input bit z,
                                output logic [31:0] r, output logic [1:0] x);
    longint unsigned pp, q, rem, half, frac;
    int sh, e;
    bit up;
    pp   = 64'(p);
    sh   = p[47] ? 24 : 23;
    e    = e_in + (p[47] ? 1 : 0);
    q    = pp >> sh;
    rem  = pp - (q << sh);
    half = 64'd1 << (sh - 1);
    up   = (rem > half) || ((rem == half) && q[0]);
    frac = (q % (64'd1 << 23)) + (up ? 64'd1 : 64'd0);
    if (frac == (64'd1 << 23)) begin
      frac = 0;
      e    = e + 1;
    end
    if (z || p == 48'd0) begin
      r = {s, 31'd0};
      x = 2'b00;
    end else if (e >= 255) begin
      r = {s, 8'hFF, 23'd0};
      x = 2'b01;
    end else if (e <= 0) begin
      r = {s, 31'd0};
      x = 2'b10;
    end else begin
      r = {s, e[7:0], frac[22:0]};
      x = 2'b00;
    end
  endfunction

  // Every cycle a result is presented it must match the oldest outstanding
  // expectation; an accepted result retires it.
  always @(negedge clk_i) begin
    if (rst_ni && out_valid_o) begin
      if (exp_res_q.size() == 0) begin
        check("unexpected_valid", {31'd0, out_valid_o}, 32'd0);
      end else begin
        check("cmp_result", result_o, exp_res_q[0]);
        check("cmp_exc", {30'd0, exc_o}, {30'd0, exp_exc_q[0]});
        if (out_ack_i) begin
          void'(exp_res_q.pop_front());
          void'(exp_exc_q.pop_front());
        end
      end
    end
  end

  task automatic issue(input logic [47:0] p, input int e, input bit s, input bit z,
                       input logic [31:0] lit_r, input logic [1:0] lit_x);
    logic [31:0] mr;
    logic [1:0]  mx;
    model(p, e, s, z, mr, mx);
    check("model_result", mr, lit_r);
    check("model_exc", {30'd0, mx}, {30'd0, lit_x});
    exp_res_q.push_back(mr);
    exp_exc_q.push_back(mx);
    prod_i       = p;
    exp_i        = 10'(e);
    sign_i       = s;
    zero_i       = z;
    prod_valid_i = 1'b1;
    @(posedge clk_i); #1;
    prod_valid_i = 1'b0;
    prod_i       = '0;
    exp_i        = '0;
    zero_i       = 1'b0;
    sign_i       = ~s;
    check("busy_after_capture", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic run(input logic [47:0] p, input int e, input bit s, input bit z,
                     input logic [31:0] lit_r, input logic [1:0] lit_x,
                     input int ack_delay, input bit poke);
    int cyc;
    logic [31:0] held;
    issue(p, e, s, z, lit_r, lit_x);
    cyc = 1;
    while (!out_valid_o && cyc < 10) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd4);
    check("lit_result", result_o, lit_r);
    check("lit_exc", {30'd0, exc_o}, {30'd0, lit_x});
    held = result_o;
    if (poke) begin
      prod_i       = 48'hFFFF_FFFF_FFFF;
      exp_i        = 10'sd200;
      prod_valid_i = 1'b1;
      @(posedge clk_i); #1;
      prod_valid_i = 1'b0;
    end
    repeat (ack_delay) begin
      @(posedge clk_i); #1;
    end
    if (poke || ack_delay > 0) begin
      check("hold_stable", result_o, held);
      check("hold_valid", {31'd0, out_valid_o}, 32'd1);
    end
    out_ack_i = 1'b1;
    @(posedge clk_i); #1;
    out_ack_i = 1'b0;
    check("valid_drop", {31'd0, out_valid_o}, 32'd0);
    check("busy_drop", {31'd0, busy_o}, 32'd0);
    check("result_kept", result_o, held);
    if (poke) begin
      repeat (6) @(posedge clk_i);
      #1;
      check("dropped_req_busy", {31'd0, busy_o}, 32'd0);
      check("dropped_req_valid", {31'd0, out_valid_o}, 32'd0);
    end
  endtask

  initial begin
    rst_ni       = 1'b1;
    prod_i       = '0;
    prod_valid_i = 1'b0;
    sign_i       = 1'b0;
    exp_i        = '0;
    zero_i       = 1'b0;
    out_ack_i    = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check("rst_result", result_o, 32'd0);
    check("rst_exc", {30'd0, exc_o}, 32'd0);
    check("rst_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;

    run(48'h9000_0000_0000, 127, 1'b0, 1'b0, 32'h4010_0000, 2'b00, 0, 1'b0);
    run(48'h4000_0040_0000, 127, 1'b0, 1'b0, 32'h3F80_0000, 2'b00, 0, 1'b0);
    run(48'h4000_00C0_0000, 127, 1'b0, 1'b0, 32'h3F80_0002, 2'b00, 0, 1'b0);
    run(48'h4000_0050_0000, 127, 1'b0, 1'b0, 32'h3F80_0001, 2'b00, 0, 1'b0);
    run(48'h7FFF_FFC0_0000, 127, 1'b0, 1'b0, 32'h4000_0000, 2'b00, 0, 1'b0);
    run(48'h8000_0000_0000, 254, 1'b0, 1'b0, 32'h7F80_0000, 2'b01, 0, 1'b0);
    run(48'hFFFF_FF80_0000, 253, 1'b1, 1'b0, 32'hFF80_0000, 2'b01, 0, 1'b0);
    run(48'h4000_0000_0000, 254, 1'b0, 1'b0, 32'h7F00_0000, 2'b00, 0, 1'b0);
    run(48'h4000_0000_0000, 1,   1'b0, 1'b0, 32'h0080_0000, 2'b00, 0, 1'b0);
    run(48'h4000_0000_0000, 0,   1'b1, 1'b0, 32'h8000_0000, 2'b10, 0, 1'b0);
    run(48'h4000_0000_0000, -5,  1'b0, 1'b0, 32'h0000_0000, 2'b10, 0, 1'b0);
    run(48'h0000_0000_0000, 127, 1'b1, 1'b0, 32'h8000_0000, 2'b00, 0, 1'b0);
    run(48'h1234_5678_9ABC, 100, 1'b1, 1'b1, 32'h8000_0000, 2'b00, 3, 1'b0);
    run(48'h9000_0000_0000, 127, 1'b1, 1'b0, 32'hC010_0000, 2'b00, 1, 1'b1);
    run(48'h4000_00C0_0000, 127, 1'b0, 1'b0, 32'h3F80_0002, 2'b00, 0, 1'b0);

    // Abort an operation while it sits in the rounding state.
    issue(48'h7FFF_FFC0_0000, 127, 1'b0, 1'b0, 32'h4000_0000, 2'b00);
    @(posedge clk_i); #1;
    #2 rst_ni = 1'b0;
    exp_res_q.delete();
    exp_exc_q.delete();
    #1;
    check("abort_valid", {31'd0, out_valid_o}, 32'd0);
    check("abort_busy", {31'd0, busy_o}, 32'd0);
    check("abort_result", result_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run(48'h9000_0000_0000, 127, 1'b0, 1'b0, 32'h4010_0000, 2'b00, 0, 1'b0);

    if (exp_res_q.size() != 0) begin
      check("scoreboard_empty", 32'(exp_res_q.size()), 32'd0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
